// File: rtl/periph_stream_master_if.sv
// Signal bundle between the stream master, its producer/controller and the
// 4-word accumulate peripheral.
interface periph_stream_master_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clr;
  logic [1:0]  cmd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] words_sent;
  logic        p_ce;
  logic        p_we;
  logic [1:0]  p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;

  modport master (
    input  in_valid, in_data, cmd_valid, cmd_clr, cmd_addr, p_rdata,
    output in_ready, cmd_ready, rd_valid, rd_data, words_sent,
           p_ce, p_we, p_addr, p_wdata
  );

  modport slave (
    output in_valid, in_data, cmd_valid, cmd_clr, cmd_addr, p_rdata,
    input  in_ready, cmd_ready, rd_valid, rd_data, words_sent,
           p_ce, p_we, p_addr, p_wdata
  );
endinterface

// File: rtl/periph_stream_master.sv
// Bus initiator for the accumulate peripheral: buffers a stream of words and
// writes each to addr 1, and serves clear/read commands strictly behind the
// buffered stream. The peripheral keeps its own registers; this block only
// sequences accesses.
module periph_stream_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 0
) (
  input logic clk,
  input logic reset,
  periph_stream_master_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FILL_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] FILL_FULL = {1'b1, {PW{1'b0}}};
  localparam logic [7:0]  GAP_LOAD  = 8'(WR_GAP);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, READ} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  gap_cnt;
  logic [7:0]  gap_next;
  logic [1:0]  rd_addr;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] fill;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] words_sent;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        cmd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FILL_FULL);

  assign push = bus.in_valid && !fifo_full;
  assign pop  = (state == WRITE);

  // Commands wait for an empty buffer, which is what keeps them behind the stream.
  assign bus.in_ready  = !fifo_full;
  assign bus.cmd_ready = (state == IDLE) && fifo_empty && (gap_cnt == 8'd0);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_data;
  assign bus.words_sent = words_sent;

  // Next-state, pacing and peripheral bus decode; the bus is idle unless a state drives it.
  always_comb begin
    state_next  = state;
    gap_next    = gap_cnt;
    bus.p_ce    = 1'b0;
    bus.p_we    = 1'b0;
    bus.p_addr  = 2'd0;
    bus.p_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (gap_cnt != 8'd0) begin
          gap_next = gap_cnt - 8'd1;
        end else if (cmd_fire) begin
          state_next = bus.cmd_clr ? CLEAR : READ;
        end else if (!fifo_empty) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        bus.p_ce    = 1'b1;
        bus.p_we    = 1'b1;
        bus.p_addr  = 2'd1;
        bus.p_wdata = fifo_mem[rd_ptr[PW-1:0]];
        if (WR_GAP > 0) begin
          gap_next   = GAP_LOAD;
          state_next = IDLE;
        end else if ((fill > FILL_ONE) || push) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        bus.p_ce   = 1'b1;
        bus.p_we   = 1'b1;
        bus.p_addr = 2'd0;
        state_next = IDLE;
      end
      READ: begin
        bus.p_ce   = 1'b1;
        bus.p_addr = rd_addr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, pacing counter and the address latched with a read command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
      rd_addr <= 2'd0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      if (cmd_fire && !bus.cmd_clr) begin
        rd_addr <= bus.cmd_addr;
      end
    end
  end

  // Buffer pointers; reset empties the buffer and discards anything pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FILL_ONE;
      if (pop)  rd_ptr <= rd_ptr + FILL_ONE;
    end
  end

  // Buffer storage; entries are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= bus.in_data;
    end
  end

  // Read capture with a one-cycle valid pulse, and the streamed-write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_data    <= 32'h0;
      words_sent <= 32'h0;
    end else begin
      rd_valid <= (state == READ);
      if (state == READ) begin
        rd_data <= bus.p_rdata;
      end
      if (state == WRITE) begin
        words_sent <= words_sent + 32'd1;
      end else if (state == CLEAR) begin
        words_sent <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_periph_stream_master.sv
// Self-checking bench for periph_stream_master: an unpaced instance with an
// accumulate-peripheral stub, plus a WR_GAP=3 instance for write pacing.
module tb_periph_stream_master;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  periph_stream_master_if bus ();
  periph_stream_master_if gbus ();

  periph_stream_master #(.FIFO_DEPTH(4), .WR_GAP(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  periph_stream_master #(.FIFO_DEPTH(4), .WR_GAP(3)) dut_gap (
    .clk(clk), .reset(reset), .bus(gbus)
  );

  // Free-running clock and cycle counter used for write spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulate peripheral stub: addr0 write clears, addr1 write adds, addr2 sum, addr3 count.
  logic [31:0] psum = 32'h0;
  logic [31:0] pcnt = 32'h0;
  always @(posedge clk) begin
    if (bus.p_ce && bus.p_we) begin
      if (bus.p_addr == 2'd0) begin
        psum <= 32'h0;
        pcnt <= 32'h0;
      end else if (bus.p_addr == 2'd1) begin
        psum <= psum + bus.p_wdata;
        pcnt <= pcnt + 32'd1;
      end
    end
  end
  assign bus.p_rdata  = (bus.p_addr == 2'd2) ? psum : (bus.p_addr == 2'd3) ? pcnt : 32'h0;
  assign gbus.p_rdata = 32'h0;

  // Reference model: accepted values in order, and what the peripheral should hold.
  logic [31:0] exp_q[$];
  logic [31:0] gexp_q[$];
  int          wr_cycles[$];
  logic [31:0] model_sum;
  logic [31:0] model_cnt;
  logic [31:0] model_words;
  logic [31:0] mon_v;
  logic [31:0] stim_v;
  int          gwrites;
  int          glast;
  bit          gstall;
  bit          ok;
  int          n_vals;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  // Offer one stream value until accepted; called and returns just after a rising edge.
  task automatic applyStimulus(input logic [31:0] value);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = value;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(value);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  // Issue a read command and check the access, the 2-cycle latency and the data.
  task automatic readReg(input logic [1:0] addr, input string tag);
    bit done = 1'b0;
    logic [31:0] want;
    bus.cmd_valid = 1'b1;
    bus.cmd_clr   = 1'b0;
    bus.cmd_addr  = addr;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    want = (addr == 2'd2) ? model_sum : model_cnt;
    @(negedge clk);
    checkOutput({tag, "_drained"}, exp_q.size(), 32'd0);
    checkOutput({tag, "_p_ctl"}, {28'h0, bus.p_ce, bus.p_we, bus.p_addr}, {28'h0, 1'b1, 1'b0, addr});
    checkOutput({tag, "_rd_valid_early"}, 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd1);
    checkOutput({tag, "_rd_data"}, bus.rd_data, want);
    @(negedge clk);
    checkOutput({tag, "_rd_pulse"}, 32'(bus.rd_valid), 32'd0);
    checkOutput({tag, "_rd_hold"}, bus.rd_data, want);
    @(posedge clk); #1;
  endtask

  // Issue a clear command and check the single addr0 write cycle.
  task automatic clearPeripheral(input string tag);
    bit done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_clr   = 1'b1;
    bus.cmd_addr  = 2'($urandom);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_clr   = 1'b0;
    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    checkOutput({tag, "_p_ctl"}, {28'h0, bus.p_ce, bus.p_we, bus.p_addr}, {28'h0, 4'b1100});
    checkOutput({tag, "_p_wdata"}, bus.p_wdata, 32'h0);
    model_sum   = 32'h0;
    model_cnt   = 32'h0;
    model_words = 32'h0;
    @(negedge clk);
    checkOutput({tag, "_one_cycle"}, 32'(bus.p_ce), 32'd0);
    checkOutput({tag, "_words"}, bus.words_sent, model_words);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0; bus.in_data  = 32'h0;
    bus.cmd_valid = 1'b0; bus.cmd_clr  = 1'b0; bus.cmd_addr  = 2'd0;
    gbus.in_valid = 1'b0; gbus.in_data = 32'h0;
    gbus.cmd_valid = 1'b0; gbus.cmd_clr = 1'b0; gbus.cmd_addr = 2'd0;
    model_sum = 32'h0; model_cnt = 32'h0; model_words = 32'h0;
    gwrites = 0; glast = 0; gstall = 1'b0;

    fork
      // Write monitors: every addr1 write must be the next accepted value, in order.
      forever begin
        @(negedge clk);
        if (!reset && bus.p_ce && bus.p_we && bus.p_addr == 2'd1) begin
          wr_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            checkOutput("wr_unexpected", 32'd1, 32'd0);
          end else begin
            mon_v = exp_q.pop_front();
            checkOutput("wr_data", bus.p_wdata, mon_v);
            model_sum   = model_sum + mon_v;
            model_cnt   = model_cnt + 32'd1;
            model_words = model_words + 32'd1;
          end
        end
        if (!reset && gbus.p_ce && gbus.p_we && gbus.p_addr == 2'd1) begin
          if (gexp_q.size() == 0) checkOutput("gwr_unexpected", 32'd1, 32'd0);
          else checkOutput("gwr_data", gbus.p_wdata, gexp_q.pop_front());
          // Three countdown cycles plus the IDLE cycle that re-arms the write.
          if (gwrites > 0) checkOutput("gwr_spacing", cyc - glast, 32'd5);
          glast   = cyc;
          gwrites = gwrites + 1;
        end
      end
      begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    // Reset state.
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_p_ctl", {28'h0, bus.p_ce, bus.p_we, bus.p_addr}, 32'h0);
    checkOutput("rst_p_wdata", bus.p_wdata, 32'h0);
    checkOutput("rst_rd", {bus.rd_data[30:0], bus.rd_valid}, 32'h0);
    checkOutput("rst_words", bus.words_sent, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: three back-to-back writes, then sum/count reads.
    wr_cycles.delete();
    applyStimulus(32'd3);
    applyStimulus(32'd5);
    applyStimulus(32'd7);
    readReg(2'd2, "t1_sum");
    readReg(2'd3, "t1_cnt");
    checkOutput("t1_words", bus.words_sent, 32'd3);
    checkOutput("t1_wr_count", wr_cycles.size(), 32'd3);
    if (wr_cycles.size() == 3) begin
      checkOutput("t1_b2b_a", wr_cycles[1] - wr_cycles[0], 32'd1);
      checkOutput("t1_b2b_b", wr_cycles[2] - wr_cycles[1], 32'd1);
    end

    // Test 2: clear, then everything reads back zero.
    clearPeripheral("t2_clr");
    readReg(2'd2, "t2_sum");
    readReg(2'd3, "t2_cnt");
    checkOutput("t2_words", bus.words_sent, 32'd0);

    // Test 4: read command offered with stream data still buffered.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd10;
    @(negedge clk);
    checkOutput("t4_in_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) exp_q.push_back(32'd10);
    @(posedge clk); #1;
    bus.in_data   = 32'd20;
    bus.cmd_valid = 1'b1;
    bus.cmd_clr   = 1'b0;
    bus.cmd_addr  = 2'd2;
    @(negedge clk);
    checkOutput("t4_cmd_blocked", 32'(bus.cmd_ready), 32'd0);
    if (bus.in_ready) exp_q.push_back(32'd20);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    readReg(2'd2, "t4_sum");

    // Test 5: 32-bit wrap of the peripheral sum.
    clearPeripheral("t5_clr");
    applyStimulus(32'hFFFF_FFFF);
    applyStimulus(32'd2);
    readReg(2'd2, "t5_sum");
    readReg(2'd3, "t5_cnt");

    // Randomized bursts with random idle gaps and occasional clears.
    for (int r = 0; r < 6; r++) begin
      n_vals = $urandom_range(1, 7);
      for (int j = 0; j < n_vals; j++) begin
        applyStimulus($urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      if ($urandom_range(0, 2) == 0) clearPeripheral("rnd_clr");
      readReg(2'd2, "rnd_sum");
      readReg(2'd3, "rnd_cnt");
      checkOutput("rnd_words", bus.words_sent, model_words);
    end

    // Test 3: paced instance, six values offered back-to-back.
    for (int i = 0; i < 6; i++) begin
      stim_v = $urandom;
      gbus.in_valid = 1'b1;
      gbus.in_data  = stim_v;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        if (gbus.in_ready) begin
          gexp_q.push_back(stim_v);
          ok = 1'b1;
        end else begin
          gstall = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!ok) checkOutput("t3_push_timeout", 32'd0, 32'd1);
    end
    gbus.in_valid = 1'b0;
    checkOutput("t3_in_ready_stall", 32'(gstall), 32'd1);
    for (int k = 0; k < 100 && gwrites < 6; k++) begin
      @(posedge clk); #1;
    end
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("t3_all_written", gwrites, 32'd6);
    checkOutput("t3_words", gbus.words_sent, 32'd6);
    checkOutput("t3_idle", {29'h0, gbus.cmd_ready, gbus.rd_valid, gbus.rd_data[0]}, 32'h4);

    // Test 6: reset in the middle of a write burst.
    for (int i = 0; i < 6; i++) applyStimulus($urandom);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.p_ce && bus.p_we) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("t6_write_seen", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_p_ce_async", 32'(bus.p_ce), 32'd0);
    exp_q.delete();
    model_words = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("t6_words", bus.words_sent, 32'd0);
    @(posedge clk); #1;
    readReg(2'd3, "t6_cnt_kept");
    readReg(2'd2, "t6_sum_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
